// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA pixel path:
//   - the default 640x480@60 timing constants,
//   - the 3-3-2 colour widths and the coordinate counter width,
//   - the helper that turns the four segment lengths into a total,
//   - the per-pixel control bundle carried down the output pipeline.
package vga_pkg;

    // Default horizontal timing, in pixels.
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FP_DEF      = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BP_DEF      = 48;

    // Default vertical timing, in lines.
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FP_DEF      = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BP_DEF      = 33;

    // Colour channel widths (3-3-2 RGB) and the PIX/LINE counter width.
    localparam int unsigned R_W   = 3;
    localparam int unsigned G_W   = 3;
    localparam int unsigned B_W   = 2;
    localparam int unsigned CNT_W = 10;

    // Total period of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned timing_total(
        input int unsigned visible,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return visible + fp + sync + bp;
    endfunction

    // Blanking and sync state of one pixel, delayed alongside its colour.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vga_ctl_t;

endpackage

// File: rtl/vga_timing_clk_en_div.sv
// clk_en_div
// Divides the system clock into a one-cycle enable pulse every CLK_DIV
// cycles. The enable is registered, so it rises in the cycle after the
// counter reaches CLK_DIV-1. With CLK_DIV = 1 the enable stays high
// from the first edge after reset release.
// Ports:
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous active-low reset
//   ce_o     out  registered enable pulse
module clk_en_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic ce_o
);

    // Four bits cover the full 1..16 divide range.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt_q;
    logic [3:0] div_cnt_d;
    logic       ce_q;
    logic       ce_d;

    // Next-state for the divide counter and the enable it produces.
    always_comb begin
        div_cnt_d = div_cnt_q;
        ce_d      = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = 4'd0;
            ce_d      = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 4'd1;
            ce_d      = 1'b0;
        end
    end

    // Counter and enable registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= 4'd0;
            ce_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ce_q      <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/vga_timing.sv
// vga_timing
// Pixel-timing engine and output stage of the VGA path. It generates the
// pixel enable and the PIX/LINE coordinates for the image source. It then
// pipelines the blanking/sync decode by two enable periods, so that it
// lines up with the colour the source returns one period after each
// coordinate, and drives the connector pins.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   CE                    pixel enable for the image source
//   PIX, LINE             current horizontal / vertical coordinate
//   R_IN, G_IN, B_IN      source colour for the previous coordinate
//   VGA_R, VGA_G, VGA_B   pin colour, zero outside the visible area
//   HSYNC, VSYNC          sync pulses, active at level SYNC_ACT
//   FRAME                 high while PIX = 0 and LINE = 0
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter logic        SYNC_ACT  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic             CE,
    output logic [CNT_W-1:0] PIX,
    output logic [CNT_W-1:0] LINE,
    input  logic [R_W-1:0]   R_IN,
    input  logic [G_W-1:0]   G_IN,
    input  logic [B_W-1:0]   B_IN,
    output logic [R_W-1:0]   VGA_R,
    output logic [G_W-1:0]   VGA_G,
    output logic [B_W-1:0]   VGA_B,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             FRAME
);

    localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

    logic             ce_s;
    logic [CNT_W-1:0] pix_q;
    logic [CNT_W-1:0] pix_d;
    logic [CNT_W-1:0] line_q;
    logic [CNT_W-1:0] line_d;
    vga_ctl_t         ctl0_s;
    vga_ctl_t         ctl1_q;
    logic [R_W-1:0]   vga_r_q;
    logic [R_W-1:0]   vga_r_d;
    logic [G_W-1:0]   vga_g_q;
    logic [G_W-1:0]   vga_g_d;
    logic [B_W-1:0]   vga_b_q;
    logic [B_W-1:0]   vga_b_d;
    logic             hsync_q;
    logic             hsync_d;
    logic             vsync_q;
    logic             vsync_d;

    clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en_div (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .ce_o    (ce_s)
    );

    // Next coordinate: PIX wraps at the end of a line and carries into LINE.
    always_comb begin
        pix_d  = pix_q;
        line_d = line_q;
        if (ce_s) begin
            if (pix_q == H_LAST) begin
                pix_d = {CNT_W{1'b0}};
                if (line_q == V_LAST) begin
                    line_d = {CNT_W{1'b0}};
                end else begin
                    line_d = line_q + CNT_W'(1);
                end
            end else begin
                pix_d = pix_q + CNT_W'(1);
            end
        end else begin
            pix_d  = pix_q;
            line_d = line_q;
        end
    end

    // Coordinate registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pix_q  <= {CNT_W{1'b0}};
            line_q <= {CNT_W{1'b0}};
        end else begin
            pix_q  <= pix_d;
            line_q <= line_d;
        end
    end

    // Blanking and sync decode of the current coordinate.
    always_comb begin
        ctl0_s.de = (pix_q < H_VIS) && (line_q < V_VIS);
        ctl0_s.hs = (pix_q >= H_SYNC_BEG) && (pix_q < H_SYNC_END);
        ctl0_s.vs = (line_q >= V_SYNC_BEG) && (line_q < V_SYNC_END);
    end

    // Stage 1: hold the decode for one period while the source fetches the colour.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctl1_q <= '{de: 1'b0, hs: 1'b0, vs: 1'b0};
        end else if (ce_s) begin
            ctl1_q <= ctl0_s;
        end else begin
            ctl1_q <= ctl1_q;
        end
    end

    // Stage 2 inputs: blank the colour and map sync onto the pin polarity.
    always_comb begin
        if (ctl1_q.de) begin
            vga_r_d = R_IN;
            vga_g_d = G_IN;
            vga_b_d = B_IN;
        end else begin
            vga_r_d = {R_W{1'b0}};
            vga_g_d = {G_W{1'b0}};
            vga_b_d = {B_W{1'b0}};
        end
        hsync_d = ctl1_q.hs ? SYNC_ACT : ~SYNC_ACT;
        vsync_d = ctl1_q.vs ? SYNC_ACT : ~SYNC_ACT;
    end

    // Stage 2: pin registers, colour and sync for the same coordinate.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vga_r_q <= {R_W{1'b0}};
            vga_g_q <= {G_W{1'b0}};
            vga_b_q <= {B_W{1'b0}};
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
        end else if (ce_s) begin
            vga_r_q <= vga_r_d;
            vga_g_q <= vga_g_d;
            vga_b_q <= vga_b_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end else begin
            vga_r_q <= vga_r_q;
            vga_g_q <= vga_g_q;
            vga_b_q <= vga_b_q;
            hsync_q <= hsync_q;
            vsync_q <= vsync_q;
        end
    end

    assign CE    = ce_s;
    assign PIX   = pix_q;
    assign LINE  = line_q;
    assign VGA_R = vga_r_q;
    assign VGA_G = vga_g_q;
    assign VGA_B = vga_b_q;
    assign HSYNC = hsync_q;
    assign VSYNC = vsync_q;
    // FRAME follows the counters directly, so it also reads high during reset.
    assign FRAME = (pix_q == {CNT_W{1'b0}}) && (line_q == {CNT_W{1'b0}});

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
// Two instances of vga_timing:
//   dut 0: default 640x480 timing, CLK_DIV = 2, active-low sync.
//   dut 1: a tiny 16x10 raster, CLK_DIV = 1, active-high sync. It is
//          small enough to run many whole frames and to take a mid-frame
//          reset.
// The reference model works from the number of clock edges since reset
// release. From that count it derives how many enable edges have occurred
// and, by division, the coordinate and the pin state. A driver pushes the
// expected observation for every clock into a per-instance queue. A monitor
// pops the queue and compares after each rising edge.
module tb_vga_timing;

    localparam int N_CYC = 4000;

    typedef struct packed {
        logic       ce;
        logic [9:0] pix;
        logic [9:0] line;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
        logic       fr;
    } obs_t;

    typedef struct {
        int d;
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        bit sact;
    } cfg_t;

    logic       clk;
    logic       rst_n [2];
    logic [2:0] r_in  [2];
    logic [2:0] g_in  [2];
    logic [1:0] b_in  [2];

    logic       ce_o   [2];
    logic [9:0] pix_o  [2];
    logic [9:0] line_o [2];
    logic [2:0] vr_o   [2];
    logic [2:0] vg_o   [2];
    logic [1:0] vb_o   [2];
    logic       hs_o   [2];
    logic       vs_o   [2];
    logic       fr_o   [2];

    obs_t act [2];
    obs_t q   [2][$];
    cfg_t cfg [2];

    int tests;
    int fails;
    int pushes;
    int prints;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing #(
        .CLK_DIV(2),
        .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VISIBLE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33),
        .SYNC_ACT(1'b0)
    ) dut0 (
        .CLK(clk), .RST_N(rst_n[0]), .CE(ce_o[0]), .PIX(pix_o[0]), .LINE(line_o[0]),
        .R_IN(r_in[0]), .G_IN(g_in[0]), .B_IN(b_in[0]),
        .VGA_R(vr_o[0]), .VGA_G(vg_o[0]), .VGA_B(vb_o[0]),
        .HSYNC(hs_o[0]), .VSYNC(vs_o[0]), .FRAME(fr_o[0])
    );

    vga_timing #(
        .CLK_DIV(1),
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_ACT(1'b1)
    ) dut1 (
        .CLK(clk), .RST_N(rst_n[1]), .CE(ce_o[1]), .PIX(pix_o[1]), .LINE(line_o[1]),
        .R_IN(r_in[1]), .G_IN(g_in[1]), .B_IN(b_in[1]),
        .VGA_R(vr_o[1]), .VGA_G(vg_o[1]), .VGA_B(vb_o[1]),
        .HSYNC(hs_o[1]), .VSYNC(vs_o[1]), .FRAME(fr_o[1])
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_act
        assign act[gi] = {ce_o[gi], pix_o[gi], line_o[gi], vr_o[gi], vg_o[gi], vb_o[gi],
                          hs_o[gi], vs_o[gi], fr_o[gi]};
    end

    function automatic int htot(cfg_t c);
        return c.hv + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(cfg_t c);
        return c.vv + c.vf + c.vs + c.vb;
    endfunction

    // Enable edges seen after k clock edges: the enable first rises after edge
    // CLK_DIV and is sampled on the following edge.
    function automatic int ce_edges(cfg_t c, int k);
        return (k >= 1) ? (k - 1) / c.d : 0;
    endfunction

    // Expected outputs after k clock edges since release (k = 0: in reset).
    function automatic obs_t model(cfg_t c, int k, logic [7:0] col);
        obs_t o;
        int   e;
        int   idx;
        int   p;
        int   l;
        e      = ce_edges(c, k);
        o.ce   = (k > 0) && (k % c.d == 0);
        o.pix  = 10'(e % htot(c));
        o.line = 10'((e / htot(c)) % vtot(c));
        o.fr   = (e % htot(c) == 0) && ((e / htot(c)) % vtot(c) == 0);
        o.r    = 3'd0;
        o.g    = 3'd0;
        o.b    = 2'd0;
        o.hs   = ~c.sact;
        o.vs   = ~c.sact;
        // Pins show the coordinate from two enable periods earlier.
        if (e >= 2) begin
            idx = e - 2;
            p   = idx % htot(c);
            l   = (idx / htot(c)) % vtot(c);
            if (p < c.hv && l < c.vv) begin
                o.r = col[7:5];
                o.g = col[4:2];
                o.b = col[1:0];
            end
            if (p >= c.hv + c.hf && p < c.hv + c.hf + c.hs) o.hs = c.sact;
            if (l >= c.vv + c.vf && l < c.vv + c.vf + c.vs) o.vs = c.sact;
        end
        return o;
    endfunction

    task automatic report(string name, obs_t a, obs_t x);
        if (prints < 20) begin
            $display("FAIL %s t=%0t actual ce=%b pix=%0d line=%0d rgb=%h/%h/%h hs=%b vs=%b fr=%b required ce=%b pix=%0d line=%0d rgb=%h/%h/%h hs=%b vs=%b fr=%b",
                     name, $time, a.ce, a.pix, a.line, a.r, a.g, a.b, a.hs, a.vs, a.fr,
                     x.ce, x.pix, x.line, x.r, x.g, x.b, x.hs, x.vs, x.fr);
        end
        prints++;
    endtask

    // Monitor: after every rising edge compare each instance with its queue head.
    initial begin
        obs_t x;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (q[i].size() > 0) begin
                    x = q[i].pop_front();
                    tests++;
                    if (act[i] !== x) begin
                        fails++;
                        report(i == 0 ? "dut0_pins" : "dut1_pins", act[i], x);
                    end
                end
            end
        end
    end

    // Driver and reference: inputs change on the falling edge.
    initial begin
        int         k [2];
        logic [7:0] last_col [2];
        bit         mid_done;
        bit         mid_now;
        int         rel_b;
        int         kn;
        int         en;
        logic [7:0] col;
        obs_t       x;

        cfg[0] = '{d: 2, hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33, sact: 1'b0};
        cfg[1] = '{d: 1, hv: 8, hf: 2, hs: 3, hb: 3, vv: 5, vf: 1, vs: 2, vb: 2, sact: 1'b1};
        tests = 0; fails = 0; pushes = 0; prints = 0;
        mid_done = 1'b0; rel_b = 0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            r_in[i] = 3'd0; g_in[i] = 3'd0; b_in[i] = 2'd0;
            k[i] = 0;
            last_col[i] = 8'd0;
        end

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            mid_now = 1'b0;
            if (cyc == 3) begin
                rst_n[0] = 1'b1;
                rst_n[1] = 1'b1;
            end
            // Reset dut1 mid-frame at LINE 3, PIX 5 of its second frame.
            if (!mid_done && rst_n[1] &&
                ce_edges(cfg[1], k[1]) == htot(cfg[1]) * vtot(cfg[1]) + 3 * htot(cfg[1]) + 5) begin
                rst_n[1] = 1'b0;
                mid_done = 1'b1;
                mid_now  = 1'b1;
                rel_b    = cyc + 4;
            end else if (mid_done && !rst_n[1] && cyc == rel_b) begin
                rst_n[1] = 1'b1;
            end

            for (int i = 0; i < 2; i++) begin
                if (!rst_n[i]) begin
                    k[i] = 0;
                    kn   = 0;
                end else begin
                    kn = k[i] + 1;
                end
                col = 8'($urandom);
                // On an enable edge present the source colour: a PIX ramp on red.
                // Between enable edges the inputs carry garbage that must be ignored.
                if (rst_n[i] && k[i] > 0 && k[i] % cfg[i].d == 0) begin
                    en = ce_edges(cfg[i], kn);
                    if (en >= 2) col[7:5] = 3'((en - 2) % htot(cfg[i]));
                    last_col[i] = col;
                end
                r_in[i] = col[7:5];
                g_in[i] = col[4:2];
                b_in[i] = col[1:0];
                q[i].push_back(model(cfg[i], kn, last_col[i]));
                pushes++;
                k[i] = kn;
            end

            // Reset must clear dut1 before any further clock edge.
            if (mid_now) begin
                #1;
                x = model(cfg[1], 0, 8'd0);
                tests++;
                if (act[1] !== x) begin
                    fails++;
                    report("async_reset", act[1], x);
                end
            end
        end

        @(posedge clk);
        #2;
        tests++;
        if (pushes != tests - 2 || q[0].size() != 0 || q[1].size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain actual pushes=%0d popped=%0d left=%0d/%0d required all popped",
                     pushes, tests - 2, q[0].size(), q[1].size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
